spmv_mem_arb: RTL and testbench
===============================

Name: spmv_mem_arb

Overview:
- Shares the single DCP NoC memory request/response port between the SpMV fetch engines: vector prefetch, row-pointer stream, column-index stream and matrix-value stream.
- Round-robin arbitrates requests through one registered output slot.
- Tags each NoC transid with the requester number and routes responses back by tag.
- Enforces a per-requester outstanding-request credit limit and reports idle/error status to the SpMV top sequencer.

Parameters:
- NUM_REQ, 4, number of requesters (1..4; transid[5:4] carries the requester index)
- PADDR_W, 40, physical address width
- DATA_W, 512, NoC response data width (one 64 B line)
- LID_W, 4, requester-local ID width (transid[3:0])
- MAX_OUTST, 16, maximum outstanding requests per requester (1..16)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_val  in  NUM_REQ  per-requester request valid
- req_rdy  out  NUM_REQ  per-requester request accepted this cycle
- req_addr  in  NUM_REQ*PADDR_W  packed addresses; requester i at [i*PADDR_W +: PADDR_W]
- req_lid  in  NUM_REQ*LID_W  packed local IDs
- mem_req_val  out  1  NoC request valid
- mem_req_rdy  in  1  NoC request ready
- mem_req_addr  out  PADDR_W  NoC request address
- mem_req_transid  out  6  {requester index[1:0], local ID[3:0]}
- mem_resp_val  in  1  NoC response valid (no backpressure)
- mem_resp_transid  in  6  response tag
- mem_resp_data  in  DATA_W  response line
- resp_val  out  NUM_REQ  one-hot response strobe to the owning requester
- resp_lid  out  LID_W  local ID of the routed response
- resp_data  out  DATA_W  routed response line
- outst_cnt  out  NUM_REQ*5  per-requester outstanding count
- arb_idle  out  1  output slot empty and all outstanding counts zero
- err_unexp  out  1  sticky: response received for a requester with zero outstanding, or with index >= NUM_REQ

Behaviour:
- Reset (async, rst_n=0): mem_req_val=0, mem_req_addr=0, mem_req_transid=0, resp_val=0, resp_lid=0, resp_data=0, all outst_cnt=0, err_unexp=0, rr pointer=0, arb_idle=1.
- Output slot is a single register.
  - slot_free = !mem_req_val || mem_req_rdy.
  - mem_req_val/addr/transid hold stable while mem_req_val && !mem_req_rdy.
- Eligibility: elig[i] = req_val[i] && outst_cnt[i] < MAX_OUTST.
- Grant:
  - Combinational round-robin over elig, starting at rr pointer and ascending with wrap.
  - req_rdy[i] = slot_free && grant[i]; at most one bit set.
  - req_rdy may depend on req_val; requesters must not make req_val depend on req_rdy.
- Accept (req_val[i] && req_rdy[i]) in cycle N:
  - Slot loads in N, so mem_req_val=1 from N+1 with addr=req_addr[i] and transid={i[1:0], req_lid[i]}.
  - rr pointer becomes (i+1) mod NUM_REQ.
  - Back-to-back accepts are allowed every cycle while mem_req_rdy=1.
- No accept: rr pointer is unchanged and mem_req_val clears after a handshake.
- Outstanding counting:
  - Issue increments outst_cnt[i] on accept, not on NoC handshake.
  - A response decrements outst_cnt of its owner.
  - Issue and response for the same requester in the same cycle leave the count unchanged.
  - The count saturates at MAX_OUTST, and the requester is masked from arbitration at MAX_OUTST.
- Response path (one-cycle registered latency): mem_resp_val in cycle N gives, in N+1:
  - resp_val one-hot at bit mem_resp_transid[5:4];
  - resp_lid = mem_resp_transid[3:0];
  - resp_data = mem_resp_data.
  - resp_val is low in any cycle without a response; resp_data/resp_lid hold their last value.
- Unexpected response (owner count 0, or index >= NUM_REQ):
  - no resp_val pulse, no decrement (no underflow);
  - err_unexp set and held until reset.
- arb_idle = !mem_req_val && all outst_cnt==0; registered-state derived, no combinational input path.
- Out-of-order responses are legal; routing uses the tag only.

Test Plan:
1. Single request: req_val[2]=1, addr=0x1000, lid=5, mem_req_rdy=1 -> req_rdy[2] in cycle 0; mem_req_val=1, addr=0x1000, transid=0x25 in cycle 1; outst_cnt[2]=1; arb_idle=0.
2. Round robin: all four req_val held high, mem_req_rdy=1, rr=0 -> grants in order 0,1,2,3,0 on consecutive cycles; transid[5:4] sequence is 0,1,2,3,0.
3. Backpressure: mem_req_rdy=0 for 3 cycles with slot full -> mem_req_addr/transid stable, all req_rdy=0; rdy=1 -> handshake, then next grant in the same cycle.
4. Credit limit: MAX_OUTST=2, requester 0 issues 2 with no responses -> req_rdy[0]=0 while requester 1 is still granted; response transid=0x03 -> resp_val=0b0001 and resp_lid=3 next cycle, outst_cnt[0]=1, requester 0 eligible again.
5. Simultaneous issue/response on requester 1 with count 1 -> count stays 1; resp_val[1] pulses.
6. Unexpected response transid=0x30 with outst_cnt[3]=0 -> no resp_val, err_unexp=1 sticky; assert rst_n=0 mid-burst -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/spmv_mem_arb.sv
// rtl/spmv_mem_arb.sv - round-robin NoC memory port arbiter with per-requester credits and tag-routed responses
module spmv_mem_arb #(
    parameter int NUM_REQ   = 4,
    parameter int PADDR_W   = 40,
    parameter int DATA_W    = 512,
    parameter int LID_W     = 4,
    parameter int MAX_OUTST = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_val,
    output logic [NUM_REQ-1:0]         req_rdy,
    input  logic [NUM_REQ*PADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LID_W-1:0]   req_lid,
    output logic                       mem_req_val,
    input  logic                       mem_req_rdy,
    output logic [PADDR_W-1:0]         mem_req_addr,
    output logic [5:0]                 mem_req_transid,
    input  logic                       mem_resp_val,
    input  logic [5:0]                 mem_resp_transid,
    input  logic [DATA_W-1:0]          mem_resp_data,
    output logic [NUM_REQ-1:0]         resp_val,
    output logic [LID_W-1:0]           resp_lid,
    output logic [DATA_W-1:0]          resp_data,
    output logic [NUM_REQ*5-1:0]       outst_cnt,
    output logic                       arb_idle,
    output logic                       err_unexp
);

    localparam int               CNT_W     = 5;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTST);
    localparam logic [1:0]       LAST_IDX  = 2'(NUM_REQ - 1);
    localparam logic [2:0]       NUM_REQ_L = 3'(NUM_REQ);

    // outstanding-request counters
    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];

    // round-robin pointer: first requester examined next cycle
    logic [1:0]         rr_q, rr_d;

    // single registered output slot towards the NoC
    logic               slot_val_q, slot_val_d;
    logic [PADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [5:0]         slot_tid_q, slot_tid_d;

    // registered response path
    logic [NUM_REQ-1:0] resp_val_q, resp_val_d;
    logic [LID_W-1:0]   resp_lid_q, resp_lid_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic               err_q, err_d;

    // arbitration and response decode
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [1:0]         grant_idx;
    logic               grant_any;
    logic [PADDR_W-1:0] grant_addr;
    logic [LID_W-1:0]   grant_lid;
    logic               slot_free;
    logic               accept;
    logic [1:0]         resp_idx;
    logic               owner_busy;
    logic               resp_hit;
    logic               resp_unexp;

    assign slot_free = !slot_val_q || mem_req_rdy;

    // a requester competes only while it holds a valid request and has credit left
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_val[i] && (cnt_q[i] < CNT_MAX);
        end
    end

    // round-robin search starting at the pointer, ascending with wrap; first eligible wins
    always_comb begin
        int         c;
        logic [1:0] cidx;
        grant      = '0;
        grant_idx  = '0;
        grant_any  = 1'b0;
        grant_addr = '0;
        grant_lid  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(rr_q) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            cidx = 2'(c);
            if (!grant_any && elig[cidx]) begin
                grant_any   = 1'b1;
                grant_idx   = cidx;
                grant[cidx] = 1'b1;
                grant_addr  = req_addr[cidx*PADDR_W +: PADDR_W];
                grant_lid   = req_lid[cidx*LID_W +: LID_W];
            end
        end
    end

    assign accept  = grant_any && slot_free;
    assign req_rdy = slot_free ? grant : '0;

    // pointer moves past the winner only when a request is actually taken
    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (grant_idx == LAST_IDX) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    // output slot: load the winner when free, hold while the NoC stalls, empty after handshake
    always_comb begin
        slot_val_d  = slot_val_q;
        slot_addr_d = slot_addr_q;
        slot_tid_d  = slot_tid_q;
        if (slot_free) begin
            slot_val_d = accept;
            if (accept) begin
                slot_addr_d = grant_addr;
                slot_tid_d  = 6'({grant_idx, grant_lid});
            end
        end
    end

    // response is routable only if its owner exists and actually has a request in flight
    always_comb begin
        resp_idx   = mem_resp_transid[5:4];
        owner_busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (resp_idx == 2'(i) && cnt_q[i] != '0) begin
                owner_busy = 1'b1;
            end
        end
        resp_hit   = mem_resp_val && ({1'b0, resp_idx} < NUM_REQ_L) && owner_busy;
        resp_unexp = mem_resp_val && !resp_hit;
    end

    // credit counters: +1 on accept, -1 on routed response, both cancel out
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            logic inc;
            logic dec;
            inc      = accept && grant[i];
            dec      = resp_hit && (resp_idx == 2'(i));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec && cnt_q[i] < CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // response strobe is a single-cycle pulse; lid/data keep the last routed value
    always_comb begin
        resp_lid_d  = resp_lid_q;
        resp_data_d = resp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_val_d[i] = resp_hit && (resp_idx == 2'(i));
        end
        if (resp_hit) begin
            resp_lid_d  = mem_resp_transid[LID_W-1:0];
            resp_data_d = mem_resp_data;
        end
        err_d = err_q || resp_unexp;
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            slot_val_q  <= 1'b0;
            slot_addr_q <= '0;
            slot_tid_q  <= '0;
            resp_val_q  <= '0;
            resp_lid_q  <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            slot_val_q  <= slot_val_d;
            slot_addr_q <= slot_addr_d;
            slot_tid_q  <= slot_tid_d;
            resp_val_q  <= resp_val_d;
            resp_lid_q  <= resp_lid_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // status derived purely from registered state
    always_comb begin
        arb_idle = !slot_val_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            outst_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
            if (cnt_q[i] != '0) begin
                arb_idle = 1'b0;
            end
        end
    end

    assign mem_req_val     = slot_val_q;
    assign mem_req_addr    = slot_addr_q;
    assign mem_req_transid = slot_tid_q;
    assign resp_val        = resp_val_q;
    assign resp_lid        = resp_lid_q;
    assign resp_data       = resp_data_q;
    assign err_unexp       = err_q;

endmodule

// File: tb/tb_spmv_mem_arb.sv
// tb/tb_spmv_mem_arb.sv - scoreboard bench for spmv_mem_arb
module tb_spmv_mem_arb;

    localparam int NR   = 4;
    localparam int AW   = 40;
    localparam int DW   = 512;
    localparam int LW   = 4;
    localparam int MAXO = 2;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_val;
    logic [NR-1:0]     req_rdy;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*LW-1:0]  req_lid;
    logic              mem_req_val;
    logic              mem_req_rdy;
    logic [AW-1:0]     mem_req_addr;
    logic [5:0]        mem_req_transid;
    logic              mem_resp_val;
    logic [5:0]        mem_resp_transid;
    logic [DW-1:0]     mem_resp_data;
    logic [NR-1:0]     resp_val;
    logic [LW-1:0]     resp_lid;
    logic [DW-1:0]     resp_data;
    logic [NR*5-1:0]   outst_cnt;
    logic              arb_idle;
    logic              err_unexp;

    int errors = 0;
    int checks = 0;

    logic [45:0]  req_sb[$];
    logic [519:0] resp_sb[$];
    int           m_cnt [NR];
    logic         m_slot;
    logic         m_err;

    spmv_mem_arb #(
        .NUM_REQ(NR), .PADDR_W(AW), .DATA_W(DW), .LID_W(LW), .MAX_OUTST(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr), .req_lid(req_lid),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_req_addr(mem_req_addr), .mem_req_transid(mem_req_transid),
        .mem_resp_val(mem_resp_val), .mem_resp_transid(mem_resp_transid),
        .mem_resp_data(mem_resp_data),
        .resp_val(resp_val), .resp_lid(resp_lid), .resp_data(resp_data),
        .outst_cnt(outst_cnt), .arb_idle(arb_idle), .err_unexp(err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_addr[i*AW +: AW] = a;
        req_lid[i*LW +: LW]  = l;
    endtask

    task automatic set_resp(input logic v, input logic [5:0] tid);
        mem_resp_val     = v;
        mem_resp_transid = tid;
        mem_resp_data    = {16{32'hC0DE0000 | {26'd0, tid}}};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_val = '0;
        mem_req_rdy = 1'b0;
        set_resp(1'b0, 6'h00);
        @(posedge clk);
        #1;
        req_sb.delete();
        resp_sb.delete();
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_slot = 1'b0;
        m_err  = 1'b0;
        rst_n  = 1'b1;
    endtask

    // one clock: record stimulus into the scoreboards, advance, compare DUT outputs
    task automatic tick();
        int           acc;
        logic [1:0]   ri;
        logic         routed;
        logic         active;
        logic [45:0]  exp_req;
        logic [519:0] exp_resp;
        #1;
        active = rst_n;
        if (active) begin
            acc = -1;
            checks++;
            if ($countones(req_rdy) > 1) begin
                errors++; $display("FAIL rdy_onehot: got %b expected at most one bit", req_rdy);
            end
            for (int i = 0; i < NR; i++) begin
                if (req_rdy[i]) begin
                    checks++;
                    if (!req_val[i] || m_cnt[i] >= MAXO || (m_slot && !mem_req_rdy)) begin
                        errors++; $display("FAIL rdy_legal: got req_rdy[%0d]=1 expected 0 (cnt=%0d)", i, m_cnt[i]);
                    end
                    if (req_val[i]) acc = i;
                end
            end
            if (mem_req_val && mem_req_rdy) begin
                checks++;
                if (req_sb.size() == 0) begin
                    errors++; $display("FAIL noc_req: got unexpected request %h expected none", {mem_req_addr, mem_req_transid});
                end else begin
                    exp_req = req_sb.pop_front();
                    if ({mem_req_addr, mem_req_transid} !== exp_req) begin
                        errors++; $display("FAIL noc_req: got %h expected %h", {mem_req_addr, mem_req_transid}, exp_req);
                    end
                end
            end
            if (!m_slot || mem_req_rdy) m_slot = (acc >= 0);
            ri     = mem_resp_transid[5:4];
            routed = mem_resp_val && (m_cnt[ri] > 0);
            exp_resp = {(routed ? 4'(1 << ri) : 4'b0000), mem_resp_transid[3:0], mem_resp_data};
            resp_sb.push_back(exp_resp);
            if (mem_resp_val && !routed) m_err = 1'b1;
            if (acc >= 0) begin
                req_sb.push_back({req_addr[acc*AW +: AW], 2'(acc), req_lid[acc*LW +: LW]});
                m_cnt[acc]++;
            end
            if (routed) m_cnt[ri]--;
        end
        @(posedge clk);
        #1;
        if (active && rst_n && resp_sb.size() > 0) begin
            exp_resp = resp_sb.pop_front();
            checks++;
            if (resp_val !== exp_resp[519:516]) begin
                errors++; $display("FAIL resp_val: got %b expected %b", resp_val, exp_resp[519:516]);
            end
            if (exp_resp[519:516] != 4'b0000) begin
                checks++;
                if ({resp_lid, resp_data} !== exp_resp[515:0]) begin
                    errors++; $display("FAIL resp_payload: got lid=%h data=%h expected lid=%h data=%h",
                                       resp_lid, resp_data[31:0], exp_resp[515:512], exp_resp[31:0]);
                end
            end
            for (int i = 0; i < NR; i++) begin
                checks++;
                if (outst_cnt[i*5 +: 5] !== 5'(m_cnt[i])) begin
                    errors++; $display("FAIL outst_cnt%0d: got %0d expected %0d", i, outst_cnt[i*5 +: 5], m_cnt[i]);
                end
            end
            checks++;
            if (err_unexp !== m_err) begin
                errors++; $display("FAIL err_unexp: got %b expected %b", err_unexp, m_err);
            end
            checks++;
            if (mem_req_val !== m_slot) begin
                errors++; $display("FAIL mem_req_val: got %b expected %b", mem_req_val, m_slot);
            end
            checks++;
            if (arb_idle !== (!m_slot && m_cnt[0] == 0 && m_cnt[1] == 0 && m_cnt[2] == 0 && m_cnt[3] == 0)) begin
                errors++; $display("FAIL arb_idle: got %b expected other", arb_idle);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_req_val !== 1'b0) begin errors++; $display("FAIL rst_mem_req_val: got %b expected 0", mem_req_val); end
        checks++; if (mem_req_addr !== '0) begin errors++; $display("FAIL rst_addr: got %h expected 0", mem_req_addr); end
        checks++; if (mem_req_transid !== 6'h00) begin errors++; $display("FAIL rst_transid: got %h expected 0", mem_req_transid); end
        checks++; if (resp_val !== 4'b0000) begin errors++; $display("FAIL rst_resp_val: got %b expected 0", resp_val); end
        checks++; if (resp_lid !== 4'h0) begin errors++; $display("FAIL rst_resp_lid: got %h expected 0", resp_lid); end
        checks++; if (resp_data !== '0) begin errors++; $display("FAIL rst_resp_data: got %h expected 0", resp_data[31:0]); end
        checks++; if (outst_cnt !== '0) begin errors++; $display("FAIL rst_outst: got %h expected 0", outst_cnt); end
        checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_unexp); end
        checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", arb_idle); end
        #1;
        checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL rst_rdy: got %b expected 0", req_rdy); end
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 40'h1000, 4'h5);
        req_val = 4'b0100;
        mem_req_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL single_rdy: got %b expected 0100", req_rdy); end
        tick();
        req_val = '0;
        checks++; if (mem_req_val !== 1'b1) begin errors++; $display("FAIL single_val: got %b expected 1", mem_req_val); end
        checks++; if (mem_req_addr !== 40'h1000) begin errors++; $display("FAIL single_addr: got %h expected 1000", mem_req_addr); end
        checks++; if (mem_req_transid !== 6'h25) begin errors++; $display("FAIL single_tid: got %h expected 25", mem_req_transid); end
        checks++; if (outst_cnt[14:10] !== 5'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", outst_cnt[14:10]); end
        checks++; if (arb_idle !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", arb_idle); end
        tick();
        set_resp(1'b1, 6'h25);
        tick();
        set_resp(1'b0, 6'h00);
        checks++; if (resp_val !== 4'b0100) begin errors++; $display("FAIL single_resp: got %b expected 0100", resp_val); end
        checks++; if (resp_lid !== 4'h5) begin errors++; $display("FAIL single_lid: got %h expected 5", resp_lid); end
        tick();
        checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL single_idle_end: got %b expected 1", arb_idle); end
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 40'(64'h2000 + 64'(i) * 64'h40), 4'(i + 8));
        req_val = 4'b1111;
        mem_req_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = k % NR;
            #1;
            checks++; if (req_rdy !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_rdy, 4'(1 << g)); end
            tick();
            checks++; if (mem_req_transid[5:4] !== 2'(g)) begin errors++; $display("FAIL rr_tid%0d: got %0d expected %0d", k, mem_req_transid[5:4], g); end
        end
        req_val = '0;
        tick();
    endtask

    task automatic test_back_to_back_stall();
        logic [AW-1:0] a0;
        do_reset();
        a0 = 40'hAB_CDEF_0040;
        set_req(0, a0, 4'h7);
        set_req(1, 40'h3000, 4'h2);
        req_val = 4'b0011;
        mem_req_rdy = 1'b0;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL bp_first: got %b expected 0001", req_rdy); end
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL bp_rdy%0d: got %b expected 0000", k, req_rdy); end
            checks++; if ({mem_req_val, mem_req_addr, mem_req_transid} !== {1'b1, a0, 6'h07}) begin
                errors++; $display("FAIL bp_hold%0d: got %h/%h expected %h/07", k, mem_req_addr, mem_req_transid, a0);
            end
            tick();
        end
        mem_req_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL bp_release: got %b expected 0010", req_rdy); end
        tick();
        checks++; if (mem_req_transid !== 6'h12) begin errors++; $display("FAIL bp_next_tid: got %h expected 12", mem_req_transid); end
        req_val = '0;
        tick();
    endtask

    task automatic test_credit();
        do_reset();
        set_req(0, 40'h4000, 4'h3);
        set_req(1, 40'h5000, 4'h1);
        req_val = 4'b0001;
        mem_req_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL credit_first: got %b expected 0001", req_rdy); end
        tick();
        #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL credit_second: got %b expected 0001", req_rdy); end
        tick();
        req_val = 4'b0011;
        #1;
        checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL credit_masked: got %b expected 0010", req_rdy); end
        tick();
        req_val = '0;
        set_resp(1'b1, 6'h03);
        tick();
        set_resp(1'b0, 6'h00);
        checks++; if (resp_val !== 4'b0001) begin errors++; $display("FAIL credit_resp: got %b expected 0001", resp_val); end
        checks++; if (resp_lid !== 4'h3) begin errors++; $display("FAIL credit_lid: got %h expected 3", resp_lid); end
        checks++; if (outst_cnt[4:0] !== 5'd1) begin errors++; $display("FAIL credit_cnt: got %0d expected 1", outst_cnt[4:0]); end
        req_val = 4'b0001;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL credit_again: got %b expected 0001", req_rdy); end
        tick();
        req_val = '0;
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_req(1, 40'h6000, 4'hA);
        req_val = 4'b0010;
        mem_req_rdy = 1'b1;
        tick();
        set_resp(1'b1, 6'h1A);
        #1;
        checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL simul_rdy: got %b expected 0010", req_rdy); end
        tick();
        req_val = '0;
        set_resp(1'b0, 6'h00);
        checks++; if (outst_cnt[9:5] !== 5'd1) begin errors++; $display("FAIL simul_cnt: got %0d expected 1", outst_cnt[9:5]); end
        checks++; if (resp_val !== 4'b0010) begin errors++; $display("FAIL simul_resp: got %b expected 0010", resp_val); end
        tick();
    endtask

    task automatic test_unexp_and_reset();
        do_reset();
        set_resp(1'b1, 6'h30);
        tick();
        set_resp(1'b0, 6'h00);
        checks++; if (resp_val !== 4'b0000) begin errors++; $display("FAIL unexp_resp: got %b expected 0000", resp_val); end
        checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_err: got %b expected 1", err_unexp); end
        checks++; if (outst_cnt[19:15] !== 5'd0) begin errors++; $display("FAIL unexp_cnt: got %0d expected 0", outst_cnt[19:15]); end
        tick();
        checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_sticky: got %b expected 1", err_unexp); end
        for (int i = 0; i < NR; i++) set_req(i, 40'(64'h7000 + 64'(i)), 4'(i));
        req_val = 4'b1111;
        mem_req_rdy = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_req_val, mem_req_addr, mem_req_transid} !== '0) begin
            errors++; $display("FAIL async_rst_slot: got %b/%h/%h expected 0", mem_req_val, mem_req_addr, mem_req_transid);
        end
        checks++; if (outst_cnt !== '0) begin errors++; $display("FAIL async_rst_cnt: got %h expected 0", outst_cnt); end
        checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL async_rst_err: got %b expected 0", err_unexp); end
        checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL async_rst_idle: got %b expected 1", arb_idle); end
        checks++; if (resp_val !== 4'b0000) begin errors++; $display("FAIL async_rst_resp: got %b expected 0", resp_val); end
        do_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        req_val = '0;
        req_addr = '0;
        req_lid = '0;
        mem_req_rdy = 1'b0;
        mem_resp_val = 1'b0;
        mem_resp_transid = '0;
        mem_resp_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back_stall();
        test_credit();
        test_simultaneous();
        test_unexp_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
